// File: rtl/gen_con.sv
// gen_con: keypad operand accumulation, operator latch and single-cycle
// add/sub/mul for the 16-bit signed calculator.
module gen_con (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  keypad_input,
  input  logic        read_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        complete,
  output logic [15:0] display_output
);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] acc_a, acc_a_n;
  logic [15:0] acc_b, acc_b_n;
  logic [15:0] result, result_n;
  logic [2:0]  op, op_n;
  logic        rd_q;
  logic        digit_ok;
  logic        op_onehot;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state  <= ENTRY_A;
      acc_a  <= '0;
      acc_b  <= '0;
      result <= '0;
      op     <= '0;
      rd_q   <= 1'b0;
    end else begin
      state  <= state_n;
      acc_a  <= acc_a_n;
      acc_b  <= acc_b_n;
      result <= result_n;
      op     <= op_n;
      rd_q   <= read_input;
    end
  end

  // Only the rising edge of the strobe counts, so a held key adds one digit.
  assign digit_ok  = read_input && !rd_q && (keypad_input <= 4'd9);
  assign op_onehot = (operator_input == 3'b001) || (operator_input == 3'b010) ||
                     (operator_input == 3'b100);

  always_comb begin
    state_n  = state;
    acc_a_n  = acc_a;
    acc_b_n  = acc_b;
    result_n = result;
    op_n     = op;
    case (state)
      ENTRY_A: begin
        if (digit_ok)
          acc_a_n = acc_a * 16'd10 + {12'd0, keypad_input};
        if (op_onehot) begin
          op_n    = operator_input;
          state_n = ENTRY_B;
        end
      end
      ENTRY_B: begin
        if (equal_input) begin
          case (op)
            3'b001:  result_n = acc_a + acc_b;
            3'b010:  result_n = acc_a - acc_b;
            3'b100:  result_n = acc_a * acc_b;
            default: result_n = '0;
          endcase
          state_n = DONE;
        end else if (digit_ok) begin
          acc_b_n = acc_b * 16'd10 + {12'd0, keypad_input};
        end
      end
      DONE:    ;
      default: state_n = ENTRY_A;
    endcase
  end

  always_comb begin
    complete       = (state == DONE);
    display_output = '0;
    case (state)
      ENTRY_A: display_output = acc_a;
      ENTRY_B: display_output = acc_b;
      DONE:    display_output = result;
      default: display_output = '0;
    endcase
  end

endmodule

// File: tb/tb_gen_con.sv
// Scoreboard bench for gen_con: a per-cycle expectation is queued by the driver
// from a behavioural calculator model and checked by an independent monitor.
module tb_gen_con;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;

  gen_con dut (
    .clk(clk), .nRST(nRST), .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input),
    .complete(complete), .display_output(display_output)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic c; logic [15:0] d; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0 = first operand, 1 = second operand, 2 = answer shown.
  int       m_phase, m_a, m_b, m_res, m_op;
  bit       m_prev;
  logic [2:0] op_lvl;

  task automatic model_step(input logic r, input int k, input logic rd,
                            input logic [2:0] o, input logic e);
    bit accept;
    if (!r) begin
      m_phase = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_prev = 0;
    end else begin
      accept = rd && !m_prev && (k <= 9);
      if (m_phase == 0) begin
        if (accept) m_a = (m_a * 10 + k) % 65536;
        if (o == 3'b001) begin m_op = 1; m_phase = 1; end
        else if (o == 3'b010) begin m_op = 2; m_phase = 1; end
        else if (o == 3'b100) begin m_op = 3; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (e) begin
          if (m_op == 1)      m_res = (m_a + m_b) & 65535;
          else if (m_op == 2) m_res = (m_a - m_b) & 65535;
          else                m_res = int'((longint'(m_a) * longint'(m_b)) & 64'hFFFF);
          m_phase = 2;
        end else if (accept) begin
          m_b = (m_b * 10 + k) % 65536;
        end
      end
      m_prev = rd;
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.c = (m_phase == 2);
    x.d = (m_phase == 0) ? 16'(m_a) : (m_phase == 1) ? 16'(m_b) : 16'(m_res);
    return x;
  endfunction

  task automatic cyc(input logic r, input int k, input logic rd,
                     input logic [2:0] o, input logic e);
    nRST = r; keypad_input = 4'(k); read_input = rd; operator_input = o; equal_input = e;
    @(posedge clk);
    model_step(r, k, rd, o, e);
    q.push_back(model_out());
    @(negedge clk);
  endtask

  // Independent monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (complete !== x.c || display_output !== x.d) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got complete=%b display=%h, expected complete=%b display=%h",
                 $time, complete, display_output, x.c, x.d);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rst();
    op_lvl = 3'b000;
    cyc(0, 0, 0, 3'b000, 0);
  endtask

  task automatic dig(input int k, input int hold);
    repeat (hold) cyc(1, k, 1, op_lvl, 0);
    cyc(1, k, 0, op_lvl, 0);
  endtask

  task automatic digits(input string s);
    for (int i = 0; i < s.len(); i++) dig(int'(s[i]) - 48, 1);
  endtask

  task automatic setop(input logic [2:0] o);
    op_lvl = o;
    cyc(1, 0, 0, o, 0);
  endtask

  task automatic calc(input string name, input string sa, input logic [2:0] o,
                      input string sb, input logic [15:0] exp);
    rst();
    digits(sa);
    setop(o);
    digits(sb);
    cyc(1, 0, 0, op_lvl, 1);
    chk({name, " complete"}, {15'd0, complete}, 16'd1);
    chk({name, " result"}, display_output, exp);
    // Equal stays held and the answer must not move.
    repeat (3) cyc(1, 5, 1, 3'b010, 1);
    chk({name, " held"}, display_output, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 0; keypad_input = 0; read_input = 0; operator_input = 0; equal_input = 0;
    rst();
    chk("reset display", display_output, 16'd0);
    chk("reset complete", {15'd0, complete}, 16'd0);

    calc("2 add 3", "2", 3'b001, "3", 16'd5);
    calc("1000 add 2345", "1000", 3'b001, "2345", 16'd3345);
    calc("3 sub 5", "3", 3'b010, "5", 16'hFFFE);
    calc("0 sub 99", "0", 3'b010, "99", 16'hFF9D);
    calc("99 sub 0", "99", 3'b010, "0", 16'd99);
    calc("128 mul 256", "128", 3'b100, "256", 16'h8000);
    calc("32767 mul 1", "32767", 3'b100, "1", 16'd32767);
    calc("100 mul 0", "100", 3'b100, "0", 16'd0);
    calc("4 mul 3", "4", 3'b100, "3", 16'd12);
    calc("wrap 70000", "70000", 3'b001, "0", 16'd4464);

    // Held strobe, invalid digit, equal ignored in the first operand.
    rst();
    dig(7, 3);
    chk("held strobe", display_output, 16'd7);
    dig(12, 1);
    chk("digit 12 ignored", display_output, 16'd7);
    cyc(1, 0, 0, 3'b011, 1);
    cyc(1, 0, 0, 3'b000, 1);
    chk("equal in A", {15'd0, complete}, 16'd0);
    chk("bad op in A", display_output, 16'd7);
    setop(3'b001);
    chk("B starts at 0", display_output, 16'd0);
    dig(4, 1);
    dig(2, 1);
    chk("B entry", display_output, 16'd42);
    cyc(1, 0, 0, op_lvl, 0);
    cyc(0, 0, 0, op_lvl, 0);
    chk("mid-B reset display", display_output, 16'd0);
    chk("mid-B reset complete", {15'd0, complete}, 16'd0);
    op_lvl = 3'b000;
    digits("4");
    setop(3'b100);
    digits("3");
    cyc(1, 0, 0, op_lvl, 1);
    chk("after reset 4 mul 3", display_output, 16'd12);

    // Digit arriving with the operator, then digit arriving with equal.
    rst();
    dig(6, 1);
    cyc(1, 5, 1, 3'b001, 0);
    op_lvl = 3'b001;
    chk("digit with operator", display_output, 16'd0);
    cyc(1, 0, 0, op_lvl, 0);
    cyc(1, 8, 1, op_lvl, 1);
    chk("digit with equal", display_output, 16'd65);

    // Randomized sessions: random strobes, junk keys, stray operators and equals.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] o;
      rst();
      o = 3'b000;
      for (int c = 0; c < 30; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0: o = 3'b001;
            1: o = 3'b010;
            2: o = 3'b100;
            default: o = 3'($urandom_range(0, 7));
          endcase
        end
        cyc(1, (($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9))),
            1'($urandom_range(0, 1)), o, ($urandom_range(0, 11) == 0));
      end
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
